dcim_shift_acc: RTL and testbench
=================================

Name: dcim_shift_acc

Overview:
- Bit-serial shift-accumulator directly downstream of the 24-bit adder-tree/CLA stage in the DCIM macro.
- Each input-activation bit plane produces one signed partial sum (psum) from the adder; this block combines IN_BITS consecutive psums, MSB plane first, into one full-precision MAC result.
- Optional two's-complement weighting of the MSB plane.
- Result is presented on a valid/ready output port with backpressure to the psum stream.

Parameters:
- PSUM_W, 24, width of incoming signed partial sum.
- IN_BITS, 8, activation bit planes per result; legal range 2..16.
- ACC_W, 32, accumulator/result width; must be >= PSUM_W+IN_BITS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clr  input  1  synchronous abort; discards any partial word, beat counter to 0; does not affect the output register.
- signed_mode  input  1  1 = MSB plane negatively weighted; sampled on beat 0 only and held for the word.
- psum_valid  input  1  psum beat present.
- psum_ready  output  1  beat accepted when psum_valid && psum_ready.
- psum  input  PSUM_W  signed partial sum for the current bit plane.
- out_valid  output  1  result held in output register.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_data  output  ACC_W  signed MAC result.
- busy  output  1  beat counter != 0 (word in progress).

Behaviour:
- Reset (rst_n=0 at edge): acc=0, beat counter=0, held signed flag=0, out_valid=0, out_data=0. Reset has priority over clr and all handshakes; a partial word is lost.
- Beat counter k runs 0..IN_BITS-1 and advances only on an accepted beat; it wraps to 0 after beat IN_BITS-1.
- psum is always sign-extended to ACC_W. Term T is -sext(psum) when k==0 and signed_mode==1, else +sext(psum).
- Accumulator update on an accepted beat:
  - k==0: acc = T. The prior acc is ignored, so no explicit clear is needed between words.
  - k>0: acc = (acc<<1) + T.
  - All arithmetic is modulo 2^ACC_W; no saturation.
- Last beat (k==IN_BITS-1): the computed value goes straight to out_data, out_valid=1 next cycle. Latency is 1 cycle from the last accepted beat to out_valid.
- The accumulator and output register are independent. The next word accumulates while a result is still held.
- psum_ready = !(k==IN_BITS-1 && out_valid && !out_ready). It stalls only the final beat of the next word. The out_ready path to psum_ready is combinational and allowed.
- Output handshake:
  - On a transfer, out_valid drops next cycle unless a new last beat is accepted the same cycle, in which case out_valid stays 1 and out_data updates (back-to-back, no bubble).
  - out_data is stable while out_valid && !out_ready.
- clr:
  - Sets k=0; any beat presented in the same cycle is dropped, and psum_ready is forced low while clr=1.
  - out_valid/out_data are untouched.
- signed_mode changes mid-word are ignored until the next beat 0.
- psum_valid=0 gaps are allowed anywhere; state holds.

Test Plan:
- Unsigned ones: signed_mode=0, psum=1 on all 8 beats, out_ready=1 -> out_data=0x000000FF, out_valid for 1 cycle, one cycle after beat 7.
- Signed ones: signed_mode=1, psum=1 on all 8 beats -> out_data=0xFFFFFFFF (-128+127=-1).
- Negative MSB: signed_mode=1, beat0 psum=0xFFFFFD (-3), beats1-7 psum=0 -> out_data=0x00000180 (+384). Same stimulus with signed_mode=0 -> 0xFFFFFE80 (-384).
- Backpressure: out_ready=0, two consecutive all-ones unsigned words -> first 0xFF held stable; second word's beats 0-6 accepted, psum_ready=0 at beat 7. Raise out_ready -> 0xFF transfers, beat 7 accepted the same cycle, next out_data=0xFF with no bubble.
- Gaps and clr: beats interleaved with psum_valid=0 cycles -> identical result to gap-free. clr after beat 3 -> busy=0, restarted word of psum=2 x8 (unsigned) -> 0x000001FE.
- Reset mid-word: rst_n=0 for 1 cycle after beat 4 while out_valid=1 -> out_valid=0, out_data=0, busy=0. A fresh word then gives the correct result.

Source files
------------

// File: rtl/dcim_shift_acc_if.sv
// Stream bundle for the shift-accumulator: psum input beats and the result port.
// The DUT takes the slave side; whoever feeds psums and drains results takes master.
interface dcim_shift_acc_if #(
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32
);
  logic              psum_valid;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;

  modport master (
    output psum_valid, psum, out_ready,
    input  psum_ready, out_valid, out_data
  );

  modport slave (
    input  psum_valid, psum, out_ready,
    output psum_ready, out_valid, out_data
  );
endinterface

// File: rtl/dcim_shift_acc.sv
// Bit-serial shift-accumulator: folds IN_BITS signed psums (MSB plane first) into
// one MAC result, with optional negative weighting of the MSB plane.
module dcim_shift_acc #(
  parameter int PSUM_W  = 24,
  parameter int IN_BITS = 8,
  parameter int ACC_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             signed_mode,
  output logic             busy,
  dcim_shift_acc_if.slave  bus
);
  localparam int              KW     = (IN_BITS > 2) ? $clog2(IN_BITS) : 1;
  localparam logic [KW-1:0]   K_ZERO = KW'(0);
  localparam logic [KW-1:0]   K_ONE  = KW'(1);
  localparam logic [KW-1:0]   K_LAST = KW'(IN_BITS - 1);

  logic [KW-1:0]    r_k;
  logic [ACC_W-1:0] r_acc;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;

  logic [ACC_W-1:0] w_sext;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_next;
  logic             w_first;
  logic             w_last;
  logic             w_ready;
  logic             w_fire;

  // Beat datapath: beat 0 loads the (possibly negated) term, later beats shift-and-add.
  // signed_mode only matters on beat 0, so no held copy of it is needed for later beats.
  always_comb begin
    w_sext  = {{(ACC_W-PSUM_W){bus.psum[PSUM_W-1]}}, bus.psum};
    w_first = (r_k == K_ZERO);
    w_last  = (r_k == K_LAST);
    if (w_first && signed_mode) begin
      w_term = -w_sext;
    end else begin
      w_term = w_sext;
    end
    if (w_first) begin
      w_next = w_term;
    end else begin
      w_next = (r_acc << 1) + w_term;
    end
    // Only the final beat can be blocked, and only by a result still waiting to leave.
    w_ready = ~clr & ~(w_last & r_out_valid & ~bus.out_ready);
    w_fire  = bus.psum_valid & w_ready;
  end

  // Beat counter and running accumulator; clr abandons the word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k   <= K_ZERO;
      r_acc <= '0;
    end else if (clr) begin
      r_k   <= K_ZERO;
      r_acc <= r_acc;
    end else if (w_fire) begin
      r_acc <= w_next;
      r_k   <= w_last ? K_ZERO : (r_k + K_ONE);
    end else begin
      r_k   <= r_k;
      r_acc <= r_acc;
    end
  end

  // Output register: loaded by the last beat, released by the consumer, untouched by clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_fire && w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_next;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
    end
  end

  assign bus.psum_ready = w_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign busy           = (r_k != K_ZERO);
endmodule

// File: tb/tb_dcim_shift_acc.sv
// Directed bench for dcim_shift_acc: expected results go into a queue at issue
// time, a negedge monitor pops and compares on every output transfer.
module tb_dcim_shift_acc;
  logic clk;
  logic rst_n;
  logic clr;
  logic signed_mode;
  logic busy;

  dcim_shift_acc_if #(.PSUM_W(24), .ACC_W(32)) bus ();

  dcim_shift_acc #(.PSUM_W(24), .IN_BITS(8), .ACC_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .signed_mode (signed_mode),
    .busy        (busy),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge when valid && ready now.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", bus.out_data, 32'hxxxxxxxx);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_out_data", bus.out_data, mon_exp);
      end
    end
  end

  // One accepted beat; signed_mode is flipped on beats >0 to prove it is ignored there.
  task automatic beat(input logic [23:0] p, input logic sm, input bit first);
    int cnt;
    cnt = 0;
    bus.psum_valid = 1'b1;
    bus.psum       = p;
    signed_mode    = first ? sm : ~sm;
    forever begin
      @(negedge clk);
      if (bus.psum_ready) break;
      cnt++;
      if (cnt > 200) begin
        check("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.psum_valid = 1'b0;
  endtask

  task automatic word(input logic [7:0][23:0] v, input logic sm, input logic [31:0] exp,
                      input int max_gap);
    sb.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      beat(v[7-i], sm, (i == 0));
      if (max_gap > 0 && i < 7) repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [7:0][23:0] v_ones, v_twos, v_neg, v_mix;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      v_ones[i] = 24'd1;
      v_twos[i] = 24'd2;
      v_neg[i]  = 24'd0;
    end
    v_neg[7] = 24'hFFFFFD;
    // MSB-first order 3,1,4,1,5,9,2,6 -> 678
    v_mix = {24'd3, 24'd1, 24'd4, 24'd1, 24'd5, 24'd9, 24'd2, 24'd6};

    rst_n = 1'b0; clr = 1'b0; signed_mode = 1'b0;
    bus.psum_valid = 1'b0; bus.psum = 24'd0; bus.out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_psum_ready", {31'd0, bus.psum_ready}, 32'd1);

    // Unsigned ones: result one cycle after beat 7, valid for a single cycle
    word(v_ones, 1'b0, 32'h000000FF, 0);
    check("ones_valid_after_last", {31'd0, bus.out_valid}, 32'd1);
    check("ones_busy_wrapped", {31'd0, busy}, 32'd0);
    tick();
    check("ones_valid_one_cycle", {31'd0, bus.out_valid}, 32'd0);

    word(v_ones, 1'b1, 32'hFFFFFFFF, 0);
    tick();
    word(v_neg, 1'b1, 32'h00000180, 0);
    tick();
    word(v_neg, 1'b0, 32'hFFFFFE80, 0);
    tick();

    // Backpressure: first result held, second word stalls only on its last beat
    bus.out_ready = 1'b0;
    word(v_ones, 1'b0, 32'h000000FF, 0);
    sb.push_back(32'h000000FF);
    for (int i = 0; i < 7; i++) beat(24'd1, 1'b0, (i == 0));
    check("bp_busy", {31'd0, busy}, 32'd1);
    bus.psum_valid = 1'b1; bus.psum = 24'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_ready", {31'd0, bus.psum_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_data", bus.out_data, 32'h000000FF);
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, bus.psum_ready}, 32'd1);
    tick();
    bus.psum_valid = 1'b0;
    check("bp_no_bubble", {31'd0, bus.out_valid}, 32'd1);
    check("bp_busy_after", {31'd0, busy}, 32'd0);
    tick();
    check("bp_drop", {31'd0, bus.out_valid}, 32'd0);

    // Gaps must not change the result
    word(v_mix, 1'b0, 32'h000002A6, 0);
    word(v_mix, 1'b0, 32'h000002A6, 3);
    tick();

    // clr after beat 3 drops the word and the beat offered alongside it
    for (int i = 0; i < 4; i++) beat(24'd7, 1'b0, (i == 0));
    bus.psum_valid = 1'b1; bus.psum = 24'd5; clr = 1'b1;
    @(negedge clk);
    check("clr_ready_low", {31'd0, bus.psum_ready}, 32'd0);
    tick();
    clr = 1'b0; bus.psum_valid = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    word(v_twos, 1'b0, 32'h000001FE, 0);
    tick();

    // Reset mid-word while a result is held
    bus.out_ready = 1'b0;
    word(v_ones, 1'b0, 32'h000000FF, 0);
    for (int i = 0; i < 5; i++) beat(24'd1, 1'b0, (i == 0));
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_valid_held", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_out_data", bus.out_data, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    bus.out_ready = 1'b1;
    word(v_ones, 1'b1, 32'hFFFFFFFF, 0);
    tick(); tick(); tick();

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
